des_key_sched_seq: RTL and testbench
====================================

DES_KEY_SCHED_SEQ -- requirements
Module: des_key_sched_seq

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 16: number of round keys issued per run, legal range 1..16.
REQ-002 SHALL have parameter SHIFT_SCHED, default 16'h8103: bit i=1 means round i rotates by 1, bit i=0 means round i rotates by 2.
REQ-003 SHALL have one clock, clk; reset is rst, synchronous and active-high.
REQ-004 Ports, in this order:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  request to begin a run
- decrypt  input  1  0 = encrypt order, 1 = decrypt order; sampled with start
- key_input  input  56  post-PC-1 key, C in [55:28], D in [27:0]; sampled with start
- busy  output  1  run in progress
- key_valid  output  1  round_key_out and round_idx are valid this cycle
- round_idx  output  4  index of the issued key, 0-based
- round_key_out  output  48  PC-2 of the current rotated C/D
- key_output  output  56  current rotated C/D state
- done  output  1  single-cycle pulse with the last key
- key_ready  input  1  downstream accepts the key; port exists only under KEY_SCHED_STALL_EN

Function
REQ-005 States: IDLE and RUN only.
REQ-006 IDLE with start=1: latch decrypt and load the C/D register; next cycle enter RUN with key_valid=1, round_idx=0.
REQ-007 Encrypt load value: C and D of key_input each rotated left by SHIFT_SCHED[0] amount.
REQ-008 Decrypt load value: C and D each rotated left by (S mod 28), S = total of all NUM_ROUNDS shift amounts. With the default parameters S=28, so the key loads unrotated.
REQ-009 Each RUN cycle that advances (see REQ-015) increments round_idx.
- Encrypt: C and D rotate left by the SHIFT_SCHED[round_idx+1] amount.
- Decrypt: C and D rotate right by the SHIFT_SCHED[NUM_ROUNDS-1-round_idx] amount.
REQ-010 Rotations SHALL apply to C and D independently, 28 bits each; bits wrap within each half only.
REQ-011 round_key_out SHALL be PC-2 of the registered C/D state, combinational from that register, and valid whenever key_valid=1.
REQ-012 On the cycle round_idx=NUM_ROUNDS-1 advances:
- done=1, coincident with the last key.
- Next cycle: IDLE, key_valid=0, busy=0.
REQ-013 busy=1 from the cycle after start is accepted through the cycle done=1.
REQ-014 start while busy=1 SHALL be ignored; key_input and decrypt are not resampled mid-run.
REQ-015 A RUN cycle advances when key_ready=1, or always when KEY_SCHED_STALL_EN is absent.
REQ-016 start on the same cycle that done=1 SHALL be ignored; a new run begins only from IDLE.
REQ-017 NUM_ROUNDS=1: a single key at round_idx=0 with done=1 in that same cycle.

Reset
REQ-018 rst=1 on any clock edge, including mid-run, SHALL force IDLE and clear the C/D register.
REQ-019 After reset, all of these read 0: busy, key_valid, done, round_idx, key_output, round_key_out (PC-2 of zero).
REQ-020 rst SHALL take priority over start.

Configuration
REQ-021 Macro KEY_SCHED_STALL_EN defined: the key_ready port exists.
- A RUN cycle with key_ready=0 holds round_idx, C/D, key_valid=1, and done.
- done stays asserted until the last key is accepted.
REQ-022 Macro KEY_SCHED_STALL_EN undefined: no key_ready port; one key is issued every clock, exactly NUM_ROUNDS consecutive cycles.

Verification
REQ-023 Encrypt, key_input=56'hF0CCAAF556678F, default parameters, no stall:
- round 0 key = 48'h1B02EFFC7072
- round 1 key = 48'h79AED9DBC9E5
- round 15 key = 48'hCB3D8B0E17F5
- done on round 15; 16 consecutive valid cycles.
REQ-024 Same key with decrypt=1:
- round 0 key = 48'hCB3D8B0E17F5
- round 15 key = 48'h1B02EFFC7072
- key_output after round 15 = 56'hF0CCAAF556678F rotated left 1 per half.
REQ-025 rst=1 pulsed at round 7 of a run: next cycle busy=0, key_valid=0, key_output=0. A following start runs a full 16 rounds from round 0.
REQ-026 start held high for the whole run with a different key_input: keys match REQ-023 exactly, and the second run starts only after busy falls.
REQ-027 KEY_SCHED_STALL_EN defined, key_ready=0 for 3 cycles at round 4: round_idx=4 and round_key_out held stable for 4 cycles total, then sequence resumes; done held until key_ready=1 on round 15.
REQ-028 NUM_ROUNDS=1, SHIFT_SCHED default, encrypt: one key 48'h1B02EFFC7072 with done=1 in the same cycle, then IDLE.

Source files
------------

// File: rtl/des_key_sched_seq.sv
// Sequential DES key schedule: issues one PC-2 round key per advancing cycle, encrypt or decrypt order.
// Optional back-pressure via key_ready is built when KEY_SCHED_STALL_EN is defined.
module des_key_sched_seq #(
    parameter int          NUM_ROUNDS  = 16,
    parameter logic [15:0] SHIFT_SCHED = 16'h8103
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [55:0] key_input,
    output logic        busy,
    output logic        key_valid,
    output logic [3:0]  round_idx,
    output logic [47:0] round_key_out,
    output logic [55:0] key_output,
    output logic        done
`ifdef KEY_SCHED_STALL_EN
    ,
    input  logic        key_ready
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

    function automatic int shift_amt(input logic [3:0] i);
        return SHIFT_SCHED[i] ? 1 : 2;
    endfunction

    function automatic int total_shift(input int n);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) begin
            s += SHIFT_SCHED[i[3:0]] ? 1 : 2;
        end
        return s;
    endfunction

    // Decrypt starts from the final encrypt state, which is the key rotated by the whole schedule.
    localparam int DEC_ROT = total_shift(NUM_ROUNDS) % 28;

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        return (x << n) | (x >> (28 - n));
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
        return (x >> n) | (x << (28 - n));
    endfunction

    function automatic logic [55:0] rot_cd_l(input logic [55:0] x, input int n);
        return {rotl28(x[55:28], n), rotl28(x[27:0], n)};
    endfunction

    function automatic logic [55:0] rot_cd_r(input logic [55:0] x, input int n);
        return {rotr28(x[55:28], n), rotr28(x[27:0], n)};
    endfunction

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state, state_next;
    logic [55:0] cd, cd_next;
    logic [3:0]  idx, idx_next;
    logic        dec, dec_next;
    logic        advance;

`ifdef KEY_SCHED_STALL_EN
    assign advance = key_ready;
`else
    assign advance = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cd    <= '0;
            idx   <= '0;
            dec   <= 1'b0;
        end else begin
            state <= state_next;
            cd    <= cd_next;
            idx   <= idx_next;
            dec   <= dec_next;
        end
    end

    // The last advance leaves C/D untouched so key_output keeps the final round's state in IDLE.
    always_comb begin
        state_next = state;
        cd_next    = cd;
        idx_next   = idx;
        dec_next   = dec;
        busy       = 1'b0;
        key_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    dec_next   = decrypt;
                    idx_next   = '0;
                    cd_next    = decrypt ? rot_cd_l(key_input, DEC_ROT)
                                         : rot_cd_l(key_input, shift_amt(4'd0));
                end
            end
            RUN: begin
                busy      = 1'b1;
                key_valid = 1'b1;
                done      = (idx == LAST_IDX);
                if (advance) begin
                    if (idx == LAST_IDX) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 4'd1;
                        cd_next  = dec ? rot_cd_r(cd, shift_amt(LAST_IDX - idx))
                                       : rot_cd_l(cd, shift_amt(idx + 4'd1));
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign round_idx  = idx;
    assign key_output = cd;

    for (genvar j = 0; j < 48; j++) begin : g_pc2
        assign round_key_out[47 - j] = cd[56 - PC2[j]];
    end

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Directed self-checking bench for des_key_sched_seq (default build, plus a NUM_ROUNDS=1 instance).
// Stall checks are compiled in when KEY_SCHED_STALL_EN is defined.
module tb_des_key_sched_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start1;
    logic        decrypt;
    logic [55:0] key_input;
    logic        key_ready;

    logic        busy, key_valid, done;
    logic [3:0]  round_idx;
    logic [47:0] round_key_out;
    logic [55:0] key_output;

    logic        busy1, key_valid1, done1;
    logic [3:0]  round_idx1;
    logic [47:0] round_key_out1;
    logic [55:0] key_output1;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [55:0] KEY_A = 56'hF0CCAAF556678F;
    localparam logic [55:0] KEY_B = 56'h0123456789ABCD;

    des_key_sched_seq dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .decrypt       (decrypt),
        .key_input     (key_input),
        .busy          (busy),
        .key_valid     (key_valid),
        .round_idx     (round_idx),
        .round_key_out (round_key_out),
        .key_output    (key_output),
        .done          (done)
`ifdef KEY_SCHED_STALL_EN
        ,
        .key_ready     (key_ready)
`endif
    );

    des_key_sched_seq #(.NUM_ROUNDS(1)) dut1 (
        .clk           (clk),
        .rst           (rst),
        .start         (start1),
        .decrypt       (decrypt),
        .key_input     (key_input),
        .busy          (busy1),
        .key_valid     (key_valid1),
        .round_idx     (round_idx1),
        .round_key_out (round_key_out1),
        .key_output    (key_output1),
        .done          (done1)
`ifdef KEY_SCHED_STALL_EN
        ,
        .key_ready     (key_ready)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Per-half left rotation of the original key by n single-bit steps.
    function automatic logic [55:0] cd_model(input logic [55:0] k, input int n);
        logic [27:0] c, d;
        c = k[55:28];
        d = k[27:0];
        for (int i = 0; i < n; i++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        return {c, d};
    endfunction

    function automatic int cum_shift(input int r);
        logic [15:0] sched;
        logic [15:0] tmp;
        int s;
        sched = 16'h8103;
        s = 0;
        for (int i = 0; i <= r; i++) begin
            tmp = sched >> i;
            s += tmp[0] ? 1 : 2;
        end
        return s;
    endfunction

    function automatic logic [47:0] pc2_model(input logic [55:0] cd);
        int t [48] = '{
            14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
            23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
            41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
            44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
        };
        logic [47:0] r;
        logic [55:0] tmp;
        r = '0;
        for (int j = 0; j < 48; j++) begin
            tmp = cd >> (56 - t[j]);
            r = {r[46:0], tmp[0]};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic d, input logic [55:0] k);
        start     = s;
        decrypt   = d;
        key_input = k;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Walks a full 16-round run starting from the cycle that shows round 0.
    task automatic runRounds(input logic dec, input logic [55:0] k, input bit known, input bit stall, input string name);
        logic [55:0] exp_cd;
        logic [47:0] exp_rk;
        for (int r = 0; r < 16; r++) begin
            exp_cd = dec ? cd_model(k, cum_shift(15 - r) % 28) : cd_model(k, cum_shift(r));
            exp_rk = pc2_model(exp_cd);
            checkOutput($sformatf("%s r%0d key_valid", name, r), 64'(key_valid), 64'(1'b1));
            checkOutput($sformatf("%s r%0d busy", name, r), 64'(busy), 64'(1'b1));
            checkOutput($sformatf("%s r%0d round_idx", name, r), 64'(round_idx), 64'(r));
            checkOutput($sformatf("%s r%0d done", name, r), 64'(done), 64'(r == 15));
            checkOutput($sformatf("%s r%0d key_output", name, r), 64'(key_output), 64'(exp_cd));
            checkOutput($sformatf("%s r%0d round_key", name, r), 64'(round_key_out), 64'(exp_rk));
            if (known && !dec && r == 0)
                checkOutput($sformatf("%s r0 const", name), 64'(round_key_out), 64'(48'h1B02EFFC7072));
            if (known && !dec && r == 1)
                checkOutput($sformatf("%s r1 const", name), 64'(round_key_out), 64'(48'h79AED9DBC9E5));
            if (known && !dec && r == 15)
                checkOutput($sformatf("%s r15 const", name), 64'(round_key_out), 64'(48'hCB3D8B0E17F5));
            if (known && dec && r == 0)
                checkOutput($sformatf("%s r0 const", name), 64'(round_key_out), 64'(48'hCB3D8B0E17F5));
            if (known && dec && r == 15)
                checkOutput($sformatf("%s r15 const", name), 64'(round_key_out), 64'(48'h1B02EFFC7072));
            if (stall && (r == 4 || r == 15)) begin
                key_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    checkOutput($sformatf("%s stall r%0d c%0d idx", name, r, s), 64'(round_idx), 64'(r));
                    checkOutput($sformatf("%s stall r%0d c%0d key", name, r, s), 64'(round_key_out), 64'(exp_rk));
                    checkOutput($sformatf("%s stall r%0d c%0d valid", name, r, s), 64'(key_valid), 64'(1'b1));
                    checkOutput($sformatf("%s stall r%0d c%0d done", name, r, s), 64'(done), 64'(r == 15));
                end
                key_ready = 1'b1;
            end
            tick();
        end
        checkOutput($sformatf("%s end busy", name), 64'(busy), 64'(1'b0));
        checkOutput($sformatf("%s end key_valid", name), 64'(key_valid), 64'(1'b0));
        checkOutput($sformatf("%s end done", name), 64'(done), 64'(1'b0));
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        start1    = 1'b0;
        decrypt   = 1'b0;
        key_input = '0;
        key_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset busy", 64'(busy), 64'(1'b0));
        checkOutput("reset key_valid", 64'(key_valid), 64'(1'b0));
        checkOutput("reset done", 64'(done), 64'(1'b0));
        checkOutput("reset round_idx", 64'(round_idx), 64'(4'd0));
        checkOutput("reset key_output", 64'(key_output), 64'(56'h0));
        checkOutput("reset round_key", 64'(round_key_out), 64'(48'h0));

        $display("[TB] encrypt run");
        applyStimulus(1'b1, 1'b0, KEY_A);
        start = 1'b0;
        runRounds(1'b0, KEY_A, 1'b1, 1'b0, "enc");
        checkOutput("enc idle key_output", 64'(key_output), 64'(KEY_A));

        $display("[TB] decrypt run");
        applyStimulus(1'b1, 1'b1, KEY_A);
        start = 1'b0;
        runRounds(1'b1, KEY_A, 1'b1, 1'b0, "dec");
        checkOutput("dec idle key_output", 64'(key_output), 64'(56'hE19955FAACCF1E));

        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 1'b0, KEY_A);
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checkOutput("midrst round_idx before", 64'(round_idx), 64'(4'd7));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst busy", 64'(busy), 64'(1'b0));
        checkOutput("midrst key_valid", 64'(key_valid), 64'(1'b0));
        checkOutput("midrst key_output", 64'(key_output), 64'(56'h0));
        applyStimulus(1'b1, 1'b0, KEY_A);
        start = 1'b0;
        runRounds(1'b0, KEY_A, 1'b1, 1'b0, "postrst");

        $display("[TB] start held through run");
        applyStimulus(1'b1, 1'b0, KEY_A);
        key_input = KEY_B;
        runRounds(1'b0, KEY_A, 1'b1, 1'b0, "held");
        tick();
        checkOutput("held restart busy", 64'(busy), 64'(1'b1));
        checkOutput("held restart idx", 64'(round_idx), 64'(4'd0));
        start = 1'b0;
        runRounds(1'b0, KEY_B, 1'b0, 1'b0, "keyb");

`ifdef KEY_SCHED_STALL_EN
        $display("[TB] stalled encrypt run");
        applyStimulus(1'b1, 1'b0, KEY_A);
        start = 1'b0;
        runRounds(1'b0, KEY_A, 1'b1, 1'b1, "stall");
`endif

        $display("[TB] single-round instance");
        decrypt   = 1'b0;
        key_input = KEY_A;
        start1    = 1'b1;
        tick();
        start1 = 1'b0;
        checkOutput("n1 key_valid", 64'(key_valid1), 64'(1'b1));
        checkOutput("n1 round_idx", 64'(round_idx1), 64'(4'd0));
        checkOutput("n1 done", 64'(done1), 64'(1'b1));
        checkOutput("n1 round_key", 64'(round_key_out1), 64'(48'h1B02EFFC7072));
        tick();
        checkOutput("n1 idle busy", 64'(busy1), 64'(1'b0));
        checkOutput("n1 idle key_valid", 64'(key_valid1), 64'(1'b0));
        checkOutput("n1 idle done", 64'(done1), 64'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
